// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program counter.
package pc_pkg;

    typedef enum logic [1:0] {
        MODE_ABS  = 2'd0,
        MODE_REL  = 2'd1,
        MODE_RET  = 2'd2,
        MODE_RSVD = 2'd3
    } redir_mode_e;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } pc_state_e;

    // Low-bit mask of an address that must be zero for a STEP-aligned target.
    function automatic logic [63:0] alignMask(input int unsigned step);
        return 64'(step) - 64'd1;
    endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Circular return-address stack; a push when full silently overwrites the oldest entry.
module pc_return_stack #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] pushData,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [XLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] topIdx;
    logic [CNT_W-1:0] count;
    logic             doPop;
    logic             overwriteTop;

    assign empty = (count == '0);
    assign top   = mem[topIdx];
    assign doPop = pop && !empty;
    // Push and pop together: the popped top is consumed and the pushed value takes its slot.
    assign overwriteTop = push && doPop;

    always_ff @(posedge clk) begin
        if (reset) begin
            topIdx <= '0;
            count  <= '0;
        end else if (overwriteTop) begin
            topIdx <= topIdx;
            count  <= count;
        end else if (push) begin
            topIdx <= topIdx + 1'b1;
            if (count != FULL_CNT) begin
                count <= count + 1'b1;
            end
        end else if (doPop) begin
            topIdx <= topIdx - 1'b1;
            count  <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (overwriteTop) begin
                mem[topIdx] <= pushData;
            end else if (push) begin
                mem[topIdx + 1'b1] <= pushData;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential fetch over valid/ready, prioritised redirects, halt/resume, RAS.
import pc_pkg::*;

module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter int              STEP         = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0010,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_addr,
    input  logic            redir_valid,
    input  logic [1:0]      redir_mode,
    input  logic [XLEN-1:0] redir_target,
    input  logic [XLEN-1:0] redir_base,
    input  logic [XLEN-1:0] redir_offset,
    input  logic            call_push,
    input  logic            trap_req,
    input  logic            trap_ret,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] epc,
    output logic            flush,
    output logic            misalign,
    output logic            ras_underflow,
    output logic            halted,
    output pc_state_e       stateDbg
);

    // Handshake: a fetch of fetch_addr is transferred on a clock edge where
    // fetch_valid && fetch_ready; fetch_valid does not depend on fetch_ready.

    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(alignMask(STEP));
    localparam logic [XLEN-1:0] STEP_W   = XLEN'(STEP);

    pc_state_e       state, stateNext;
    logic [XLEN-1:0] pc, pcNext;
    logic [XLEN-1:0] epcNext;
    logic            flushNext, misalignNext, underflowNext;
    logic            rasPush, rasPop, rasEmpty;
    logic [XLEN-1:0] rasTop;
    logic [XLEN-1:0] redirDest;
    redir_mode_e     mode;
    logic            redirApplies;

    assign mode         = redir_mode_e'(redir_mode);
    assign redirApplies = redir_valid && (mode != MODE_RSVD);
    assign fetch_valid  = (state == ST_RUN);
    assign fetch_addr   = pc;
    assign halted       = (state == ST_HALTED);
    assign stateDbg     = state;

    pc_return_stack #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (rasPush),
        .pop      (rasPop),
        .pushData (redir_base + STEP_W),
        .top      (rasTop),
        .empty    (rasEmpty)
    );

    always_comb begin
        redirDest = redir_target;
        case (mode)
            MODE_ABS: redirDest = redir_target;
            MODE_REL: redirDest = redir_base + redir_offset;
            MODE_RET: redirDest = rasEmpty ? redir_target : rasTop;
            default:  redirDest = redir_target;
        endcase
    end

    always_comb begin
        stateNext     = state;
        pcNext        = pc;
        epcNext       = epc;
        flushNext     = 1'b0;
        misalignNext  = 1'b0;
        underflowNext = 1'b0;
        rasPush       = 1'b0;
        rasPop        = 1'b0;

        case (state)
            ST_BOOT:   stateNext = ST_RUN;
            ST_RUN:    if (halt_req) stateNext = ST_HALTED;
            ST_HALTED: if (resume && !halt_req) stateNext = ST_RUN;
            default:   stateNext = ST_BOOT;
        endcase

        // BOOT ignores every request; elsewhere only the highest-priority request acts.
        if (state != ST_BOOT) begin
            if (trap_req) begin
                stateNext = ST_RUN;
                epcNext   = pc;
                pcNext    = TRAP_VECTOR;
                flushNext = 1'b1;
            end else if (trap_ret) begin
                flushNext = 1'b1;
                if ((epc & LOW_MASK) != '0) begin
                    pcNext       = TRAP_VECTOR;
                    misalignNext = 1'b1;
                end else begin
                    pcNext = epc;
                end
            end else if (redirApplies) begin
                flushNext = 1'b1;
                rasPush   = call_push;
                if (mode == MODE_RET) begin
                    rasPop        = !rasEmpty;
                    underflowNext = rasEmpty;
                end
                if ((redirDest & LOW_MASK) != '0) begin
                    pcNext       = TRAP_VECTOR;
                    epcNext      = redirDest;
                    misalignNext = 1'b1;
                end else begin
                    pcNext = redirDest;
                end
            end else if (fetch_valid && fetch_ready) begin
                pcNext = pc + STEP_W;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_BOOT;
            pc            <= RESET_VECTOR;
            epc           <= '0;
            flush         <= 1'b0;
            misalign      <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            state         <= stateNext;
            pc            <= pcNext;
            epc           <= epcNext;
            flush         <= flushNext;
            misalign      <= misalignNext;
            ras_underflow <= underflowNext;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch stepping, stalls, redirects, RAS, traps, misalign and halt.
import pc_pkg::*;

module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_addr;
    logic        redir_valid;
    logic [1:0]  redir_mode;
    logic [31:0] redir_target;
    logic [31:0] redir_base;
    logic [31:0] redir_offset;
    logic        call_push;
    logic        trap_req;
    logic        trap_ret;
    logic        halt_req;
    logic        resume;
    logic [31:0] epc;
    logic        flush;
    logic        misalign;
    logic        ras_underflow;
    logic        halted;
    pc_state_e   stateDbg;

    int total = 0;
    int bad   = 0;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_valid   (fetch_valid),
        .fetch_ready   (fetch_ready),
        .fetch_addr    (fetch_addr),
        .redir_valid   (redir_valid),
        .redir_mode    (redir_mode),
        .redir_target  (redir_target),
        .redir_base    (redir_base),
        .redir_offset  (redir_offset),
        .call_push     (call_push),
        .trap_req      (trap_req),
        .trap_ret      (trap_ret),
        .halt_req      (halt_req),
        .resume        (resume),
        .epc           (epc),
        .flush         (flush),
        .misalign      (misalign),
        .ras_underflow (ras_underflow),
        .halted        (halted),
        .stateDbg      (stateDbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clearReq();
        redir_valid = 1'b0;
        redir_mode  = 2'd0;
        call_push   = 1'b0;
        trap_req    = 1'b0;
        trap_ret    = 1'b0;
        halt_req    = 1'b0;
        resume      = 1'b0;
    endtask

    task automatic redirect(input logic [1:0] m, input logic [31:0] tgt,
                            input logic [31:0] base, input logic [31:0] off, input logic push);
        redir_valid  = 1'b1;
        redir_mode   = m;
        redir_target = tgt;
        redir_base   = base;
        redir_offset = off;
        call_push    = push;
    endtask

    initial begin
        clearReq();
        redir_target = '0;
        redir_base   = '0;
        redir_offset = '0;
        fetch_ready  = 1'b0;
        reset        = 1'b1;
        tick();
        tick();

        // Reset state: BOOT, no fetch, PC at reset vector.
        check("reset_valid", 32'(fetch_valid), 32'd0);
        check("reset_addr", fetch_addr, 32'h0);
        check("reset_epc", epc, 32'h0);
        check("reset_flags", {28'd0, flush, misalign, ras_underflow, halted}, 32'd0);
        check("reset_state", 32'(stateDbg), 32'(ST_BOOT));

        // BOOT ignores fetch_ready; then sequential stepping.
        reset       = 1'b0;
        fetch_ready = 1'b1;
        tick();
        check("boot_exit_valid", 32'(fetch_valid), 32'd1);
        check("fetch0", fetch_addr, 32'h0);
        tick();
        check("fetch1", fetch_addr, 32'h4);
        tick();
        check("fetch2", fetch_addr, 32'h8);

        // Stall for three cycles, then release.
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", fetch_addr, 32'h8);
        end
        fetch_ready = 1'b1;
        tick();
        check("stall_release", fetch_addr, 32'hC);

        // REL redirect with a same-cycle accepted fetch: redirect wins.
        redirect(2'd1, 32'h0, 32'h100, 32'hFFFF_FFF8, 1'b0);
        tick();
        check("rel_addr", fetch_addr, 32'hF8);
        check("rel_flush", 32'(flush), 32'd1);
        clearReq();
        fetch_ready = 1'b0;
        tick();
        check("flush_pulse_end", 32'(flush), 32'd0);
        check("rel_hold", fetch_addr, 32'hF8);

        // Call push with ABS jump, RET pops, RET on empty falls back with underflow.
        redirect(2'd0, 32'h200, 32'h20, 32'h0, 1'b1);
        tick();
        check("call_addr", fetch_addr, 32'h200);
        redirect(2'd2, 32'h300, 32'h0, 32'h0, 1'b0);
        tick();
        check("ret_addr", fetch_addr, 32'h24);
        check("ret_no_underflow", 32'(ras_underflow), 32'd0);
        tick();
        check("ret_empty_addr", fetch_addr, 32'h300);
        check("ret_underflow", 32'(ras_underflow), 32'd1);
        clearReq();
        tick();
        check("underflow_pulse_end", 32'(ras_underflow), 32'd0);

        // Reserved mode is ignored.
        redirect(2'd3, 32'h500, 32'h0, 32'h0, 1'b0);
        tick();
        check("rsvd_addr", fetch_addr, 32'h300);
        check("rsvd_flush", 32'(flush), 32'd0);
        clearReq();

        // Trap beats a same-cycle redirect; trap_ret returns to epc.
        redirect(2'd0, 32'h40, 32'h0, 32'h0, 1'b0);
        tick();
        check("goto_40", fetch_addr, 32'h40);
        redirect(2'd0, 32'h80, 32'h0, 32'h0, 1'b0);
        trap_req = 1'b1;
        tick();
        check("trap_addr", fetch_addr, 32'h10);
        check("trap_epc", epc, 32'h40);
        check("trap_flush", 32'(flush), 32'd1);
        clearReq();
        trap_ret = 1'b1;
        tick();
        check("trap_ret_addr", fetch_addr, 32'h40);
        check("trap_ret_flush", 32'(flush), 32'd1);
        clearReq();

        // Misaligned ABS target traps with the bad target in epc.
        redirect(2'd0, 32'h102, 32'h0, 32'h0, 1'b0);
        tick();
        check("mis_addr", fetch_addr, 32'h10);
        check("mis_epc", epc, 32'h102);
        check("mis_flag", 32'(misalign), 32'd1);
        clearReq();
        tick();
        check("mis_pulse_end", 32'(misalign), 32'd0);

        // Halt: the halting cycle still fetches, then PC freezes until resume.
        fetch_ready = 1'b1;
        halt_req    = 1'b1;
        tick();
        check("halted", 32'(halted), 32'd1);
        check("halt_valid", 32'(fetch_valid), 32'd0);
        check("halt_addr", fetch_addr, 32'h14);
        tick();
        check("halt_frozen", fetch_addr, 32'h14);
        halt_req = 1'b0;
        resume   = 1'b1;
        tick();
        check("resume_halted", 32'(halted), 32'd0);
        check("resume_addr", fetch_addr, 32'h14);
        resume = 1'b0;
        tick();
        check("resume_step", fetch_addr, 32'h18);

        // Push and pop in the same cycle: old top is returned, new value replaces it.
        fetch_ready = 1'b0;
        redirect(2'd0, 32'h700, 32'h60, 32'h0, 1'b1);
        tick();
        check("push2_addr", fetch_addr, 32'h700);
        redirect(2'd2, 32'h900, 32'h80, 32'h0, 1'b1);
        tick();
        check("pushpop_addr", fetch_addr, 32'h64);
        redirect(2'd2, 32'h900, 32'h0, 32'h0, 1'b0);
        tick();
        check("pushpop_next", fetch_addr, 32'h84);
        tick();
        check("pushpop_empty", fetch_addr, 32'h900);
        clearReq();

        // Reset mid-operation returns everything to reset values.
        reset = 1'b1;
        tick();
        check("midreset_addr", fetch_addr, 32'h0);
        check("midreset_epc", epc, 32'h0);
        check("midreset_valid", 32'(fetch_valid), 32'd0);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
